// File: rtl/barrett_an_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : barrett_an_decoder_pipe
//  Purpose  : Pipelined AN-code decoder. Each accepted codeword is divided by
//             the code constant A using Barrett reduction (multiply by
//             M = floor(2^K / A), shift right by K, then one conditional
//             correction step). Results stream out on a valid/ready port,
//             with a saturating counter of errored results transferred.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          clock, all logic on rising edge
//    rst        in   1          synchronous active-high reset
//    in_valid   in   1          codeword present
//    in_ready   out  1          block can accept a codeword
//    codeword   in   CW_W       received AN codeword
//    out_valid  out  1          result present
//    out_ready  in   1          consumer accepts result
//    q          out  Q_W        corrected quotient (decoded data)
//    r          out  R_W        corrected remainder, 0 <= r < A
//    error      out  1          1 iff r != 0
//    receive    out  CW_W       codeword that produced this result
//    err_clr    in   1          synchronous clear of err_cnt
//    err_cnt    out  ERR_CNT_W  saturating count of errored results sent
// ============================================================================
module barrett_an_decoder_pipe #(
    parameter  int A         = 13,
    parameter  int CW_W      = 6,
    parameter  int K         = 7,
    parameter  int ERR_CNT_W = 16,
    localparam int Q_W       = ($clog2(((1 << CW_W) - 1) / A + 1) < 1) ? 1
                               : $clog2(((1 << CW_W) - 1) / A + 1),
    localparam int R_W       = $clog2(A)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW_W-1:0]      codeword,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Q_W-1:0]       q,
    output logic [R_W-1:0]       r,
    output logic                 error,
    output logic [CW_W-1:0]      receive,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Barrett multiplier and the product width that holds codeword*M exactly
    localparam int             c_m      = (1 << K) / A;
    localparam int             c_prod_w = CW_W + $clog2(c_m + 1);
    localparam logic [R_W:0]   c_a_ext  = (R_W + 1)'(A);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                 r_s1_valid;
    logic [CW_W-1:0]      r_s1_cw;
    logic [Q_W-1:0]       r_s1_qest;

    logic                 r_s2_valid;
    logic [CW_W-1:0]      r_s2_cw;
    logic [Q_W-1:0]       r_s2_qest;
    logic [R_W:0]         r_s2_rtmp;

    logic                 r_out_valid;
    logic [Q_W-1:0]       r_q;
    logic [R_W-1:0]       r_r;
    logic                 r_error;
    logic [CW_W-1:0]      r_receive;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic                 w_adv;
    logic [c_prod_w-1:0]  w_prod;
    logic [Q_W-1:0]       w_s1_qest;
    logic [CW_W-1:0]      w_qa;
    logic [CW_W-1:0]      w_diff;
    logic [R_W:0]         w_s2_rtmp;
    logic [R_W:0]         w_sub;
    logic                 w_ge;
    logic [Q_W-1:0]       w_q;
    logic [R_W-1:0]       w_r;
    logic                 w_out_xfer;

    // A single global enable: the whole pipe moves whenever the output
    // register is empty or being drained this cycle.
    assign w_adv      = ~r_out_valid | out_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Stage 1: full-width product, then shift. q_est never exceeds the true
    // quotient, so it always fits in Q_W bits after the shift.
    assign w_prod    = c_prod_w'(codeword) * c_prod_w'(c_m);
    assign w_s1_qest = Q_W'(w_prod >> K);

    // Stage 2: q_est*A <= codeword, so the subtraction never wraps and the
    // difference lies in [0, 2A-1], which fits in R_W+1 bits.
    assign w_qa      = CW_W'(r_s1_qest) * CW_W'(A);
    assign w_diff    = r_s1_cw - w_qa;
    assign w_s2_rtmp = (R_W + 1)'(w_diff);

    // Stage 3: at most one correction step is ever needed.
    assign w_sub = r_s2_rtmp - c_a_ext;
    assign w_ge  = (r_s2_rtmp >= c_a_ext);
    assign w_q   = w_ge ? (r_s2_qest + Q_W'(1)) : r_s2_qest;
    assign w_r   = w_ge ? R_W'(w_sub) : R_W'(r_s2_rtmp);

    // ------------------------------------------------------------------
    // Pipeline advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_cw     <= '0;
            r_s1_qest   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_cw     <= '0;
            r_s2_qest   <= '0;
            r_s2_rtmp   <= '0;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_error     <= 1'b0;
            r_receive   <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            // Data registers only load behind a valid slot so that bubbles
            // leave the previous contents untouched.
            if (in_valid) begin
                r_s1_cw   <= codeword;
                r_s1_qest <= w_s1_qest;
            end
            if (r_s1_valid) begin
                r_s2_cw   <= r_s1_cw;
                r_s2_qest <= r_s1_qest;
                r_s2_rtmp <= w_s2_rtmp;
            end
            if (r_s2_valid) begin
                r_q       <= w_q;
                r_r       <= w_r;
                r_error   <= (w_r != '0);
                r_receive <= r_s2_cw;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counter; clear has priority over increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_out_xfer && r_error && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign r         = r_r;
    assign error     = r_error;
    assign receive   = r_receive;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_barrett_an_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barrett_an_decoder_pipe
//  Purpose  : Self-checking bench for barrett_an_decoder_pipe. Instance A uses
//             A=13 CW_W=6 K=7; instance B uses A=7 CW_W=10 K=13 ERR_CNT_W=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_barrett_an_decoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic err_clr;

    // Instance A signals
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_error;
    logic [5:0]  a_codeword, a_receive;
    logic [2:0]  a_q;
    logic [3:0]  a_r;
    logic [15:0] a_err_cnt;

    // Instance B signals
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_error;
    logic [9:0]  b_codeword, b_receive;
    logic [7:0]  b_q;
    logic [2:0]  b_r;
    logic [1:0]  b_err_cnt;

    barrett_an_decoder_pipe #(.A(13), .CW_W(6), .K(7), .ERR_CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .codeword(a_codeword),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .q(a_q), .r(a_r), .error(a_error), .receive(a_receive),
        .err_clr(err_clr), .err_cnt(a_err_cnt)
    );

    barrett_an_decoder_pipe #(.A(7), .CW_W(10), .K(13), .ERR_CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .codeword(b_codeword),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .q(b_q), .r(b_r), .error(b_error), .receive(b_receive),
        .err_clr(err_clr), .err_cnt(b_err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboards: accepted codewords queued, results checked in order
    // against integer div/mod, held outputs checked while stalled.
    // ------------------------------------------------------------------
    logic [5:0]  a_sb[$];
    int          a_out_cnt = 0;
    logic        a_hold = 1'b0;
    logic [13:0] a_held;

    always @(negedge clk) begin
        logic [5:0] cw;
        if (rst) begin
            a_sb.delete();
            a_hold = 1'b0;
        end else begin
            if (a_hold)
                check_value("a_stall_hold", {a_out_valid, a_q, a_r, a_error, a_receive}, {1'b1, a_held});
            if (a_out_valid && a_out_ready) begin
                check_value("a_sb_nonempty", a_sb.size() != 0, 1);
                if (a_sb.size() != 0) begin
                    cw = a_sb.pop_front();
                    check_value("a_q", a_q, cw / 13);
                    check_value("a_r", a_r, cw % 13);
                    check_value("a_err", a_error, (cw % 13) != 0);
                    check_value("a_receive", a_receive, cw);
                end
                a_out_cnt++;
            end
            if (a_in_valid && a_in_ready)
                a_sb.push_back(a_codeword);
            a_hold = a_out_valid && !a_out_ready;
            a_held = {a_q, a_r, a_error, a_receive};
        end
    end

    logic [9:0]  b_sb[$];
    int          b_out_cnt = 0;

    always @(negedge clk) begin
        logic [9:0] cw;
        if (rst) begin
            b_sb.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                check_value("b_sb_nonempty", b_sb.size() != 0, 1);
                if (b_sb.size() != 0) begin
                    cw = b_sb.pop_front();
                    check_value("b_q", b_q, cw / 7);
                    check_value("b_r", b_r, cw % 7);
                    check_value("b_err", b_error, (cw % 7) != 0);
                    check_value("b_receive", b_receive, cw);
                end
                b_out_cnt++;
            end
            if (b_in_valid && b_in_ready)
                b_sb.push_back(b_codeword);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic spot_a(input int cw, input int eq, input int er, input int ee);
        logic found;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_codeword = 6'(cw);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (a_out_valid) found = 1'b1;
        end
        check_value("spot_found", found, 1);
        check_value("spot_q", a_q, eq);
        check_value("spot_r", a_r, er);
        check_value("spot_err", a_error, ee);
    endtask

    task automatic send_b(input int cw);
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_codeword = 10'(cw);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int sent, guard, base, seen;
        logic acc;

        rst = 1'b1; err_clr = 1'b0;
        a_in_valid = 1'b0; a_codeword = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_codeword = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_value("rst_out_valid", a_out_valid, 0);
        check_value("rst_in_ready", a_in_ready, 1);
        check_value("rst_q", a_q, 0);
        check_value("rst_r", a_r, 0);
        check_value("rst_err", a_error, 0);
        check_value("rst_receive", a_receive, 0);
        check_value("rst_err_cnt", a_err_cnt, 0);
        check_value("rst_b_out_valid", b_out_valid, 0);

        // Exhaustive A=13: stream all 64 codewords back to back, first result
        // appears after the third rising edge counting the accept edge.
        for (int i = 0; i < 68; i++) begin
            @(posedge clk); #1;
            a_in_valid = (i < 64);
            a_codeword = 6'(i);
            if (i <= 3) begin
                @(negedge clk);
                check_value("a_latency", a_out_valid, i == 3);
            end
        end
        a_in_valid = 1'b0;
        idle(4);
        check_value("a_exh_count", a_out_cnt, 64);
        // 64 codewords minus the 5 multiples of 13 (0,13,26,39,52)
        check_value("a_exh_err_cnt", a_err_cnt, 59);

        // Spot checks, including the correction path and both extremes
        spot_a(39, 3, 0, 0);
        spot_a(52, 4, 0, 0);
        spot_a(63, 4, 11, 1);
        spot_a(0, 0, 0, 0);
        spot_a(14, 1, 1, 1);

        // Backpressure: random valid/ready, 1000 items
        idle(3);
        base = a_out_cnt;
        sent = 0; guard = 0; acc = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
            a_out_ready = ($urandom_range(0, 3) != 0);
            if (!a_in_valid || acc) begin
                a_in_valid = ($urandom_range(0, 3) != 0);
                a_codeword = 6'($urandom_range(0, 63));
            end
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (acc) sent++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        idle(6);
        check_value("a_bp_guard", guard < 20000, 1);
        check_value("a_bp_count", a_out_cnt - base, 1000);
        check_value("a_bp_sb_empty", a_sb.size(), 0);

        // Reset with three items in flight
        a_out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            a_in_valid = 1'b1;
            a_codeword = 6'(i);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        check_value("a_inflight_valid", a_out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_value("a_midrst_out_valid", a_out_valid, 0);
        check_value("a_midrst_err_cnt", a_err_cnt, 0);
        a_out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check_value("a_midrst_no_emerge", seen, 0);

        // Exhaustive A=7 CW_W=10 K=13
        base = b_out_cnt;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1;
            b_codeword = 10'(i);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        idle(6);
        check_value("b_exh_count", b_out_cnt - base, 1024);
        check_value("b_exh_err_sat", b_err_cnt, 3);

        // Two-bit counter: clear, count up, saturate
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check_value("b_clr", b_err_cnt, 0);
        send_b(1);
        send_b(2);
        idle(5);
        check_value("b_cnt_2", b_err_cnt, 2);
        send_b(3);
        send_b(4);
        send_b(5);
        idle(5);
        check_value("b_cnt_sat", b_err_cnt, 3);

        // Clear coincident with an errored transfer
        b_out_ready = 1'b0;
        send_b(8);
        idle(4);
        @(negedge clk);
        check_value("b_hold_valid", b_out_valid, 1);
        base = b_out_cnt;
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check_value("b_clr_xfer_done", b_out_cnt - base, 1);
        check_value("b_clr_wins", b_err_cnt, 0);
        send_b(9);
        idle(5);
        check_value("b_cnt_after_clr", b_err_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
